// File: rtl/mem_io_unit.sv
// ---------------------------------------------------------------------------
// mem_io_unit
//   Memory-stage consumer for the pipelined MIPS core. Each M-stage access is
//   routed to the synchronous data memory (ALUOutM[31] = 0) or to a small
//   memory-mapped I/O space (ALUOutM[31] = 1). The I/O space holds UART TX/RX
//   byte FIFOs, a status register and a free-running cycle counter. Load data
//   comes back one cycle after MemReadM, which matches the data-memory latency.
//
//   I/O map (ALUOutM[7:2], ALUOutM[1:0] ignored):
//     0x00 STATUS  read : {29'b0, tx_overflow, rx_not_empty, tx_not_full}
//     0x04 RXDATA  read : {24'b0, rx head}, pops the RX FIFO (0 if empty)
//     0x08 TXDATA  write: pushes WriteDataM[7:0] when MaskM[0] is set
//     0x10 CYCLES  read : cycle counter; any store clears it
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   ALUOutM       M-stage byte address
//   WriteDataM    M-stage store data
//   MaskM         byte write enables (any bit set = store)
//   MemReadM      M-stage load strobe
//   ReadDataM     load data, valid the cycle after MemReadM
//   dmem_*        synchronous data-memory interface (1-cycle read latency)
//   tx_*          UART transmitter handshake (FIFO head out)
//   rx_*          UART receiver handshake (FIFO tail in)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// mem_io_fifo
//   Byte FIFO used for both UART directions. A push while full is accepted
//   only if a pop happens in the same cycle (the pop frees the slot).
//
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_wdata push request and data
//   i_pop           pop request (ignored while empty)
//   o_head          oldest entry
//   o_empty, o_full occupancy flags
// ---------------------------------------------------------------------------
module mem_io_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    // When full, the slot being popped this cycle is the one written.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

module mem_io_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int DMEM_AW    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ALUOutM,
    input  logic [31:0]        WriteDataM,
    input  logic [3:0]         MaskM,
    input  logic               MemReadM,
    output logic [31:0]        ReadDataM,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready
);

    // Word offsets within the I/O page (ALUOutM[7:2]).
    localparam logic [5:0] REG_STATUS = 6'h00;
    localparam logic [5:0] REG_RXDATA = 6'h01;
    localparam logic [5:0] REG_TXDATA = 6'h02;
    localparam logic [5:0] REG_CYCLES = 6'h04;

    // Registered state
    logic        r_sel_q;
    logic [31:0] r_io_rdata_q;
    logic        r_tx_ovf;
    logic [31:0] r_cycles;

    // Decode
    logic        w_io_sel;
    logic        w_store;
    logic [5:0]  w_reg;
    logic        w_io_rd;
    logic        w_status_rd;
    logic        w_rx_rd;
    logic        w_tx_wr;
    logic        w_cyc_clr;

    // FIFO interface
    logic [7:0]  w_tx_head;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_tx_pop;
    logic        w_tx_ovf_evt;
    logic [7:0]  w_rx_head;
    logic        w_rx_empty;
    logic        w_rx_full;
    logic        w_rx_push;
    logic        w_rx_pop;

    logic [31:0] w_io_rdata;
    logic        w_unused;

    // Only some address bits are decoded; the rest are don't-care.
    assign w_unused    = ^ALUOutM;

    assign w_io_sel    = ALUOutM[31];
    assign w_store     = |MaskM;
    assign w_reg       = ALUOutM[7:2];
    assign w_io_rd     = w_io_sel & MemReadM;
    assign w_status_rd = w_io_rd & (w_reg == REG_STATUS);
    assign w_rx_rd     = w_io_rd & (w_reg == REG_RXDATA);
    assign w_tx_wr     = w_io_sel & MaskM[0] & (w_reg == REG_TXDATA);
    assign w_cyc_clr   = w_io_sel & w_store & (w_reg == REG_CYCLES);

    // Data-memory side: stores into I/O space never reach memory.
    assign dmem_addr   = ALUOutM[DMEM_AW+1:2];
    assign dmem_we     = w_io_sel ? 4'b0000 : MaskM;
    assign dmem_wdata  = WriteDataM;

    // TX direction
    assign tx_valid     = ~w_tx_empty;
    assign tx_data      = w_tx_head;
    assign w_tx_pop     = ~w_tx_empty & tx_ready;
    // A full FIFO still takes the byte when a pop happens in the same cycle.
    assign w_tx_ovf_evt = w_tx_wr & w_tx_full & ~w_tx_pop;

    mem_io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_tx_wr),
        .i_wdata (WriteDataM[7:0]),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    // RX direction
    assign rx_ready  = ~w_rx_full;
    assign w_rx_push = rx_valid & ~w_rx_full;
    assign w_rx_pop  = w_rx_rd & ~w_rx_empty;

    mem_io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_rx_push),
        .i_wdata (rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    // I/O read mux, sampled from pre-edge state.
    always_comb begin
        w_io_rdata = '0;
        if (w_io_rd) begin
            case (w_reg)
                REG_STATUS: w_io_rdata = {29'b0, r_tx_ovf, ~w_rx_empty, ~w_tx_full};
                REG_RXDATA: w_io_rdata = w_rx_empty ? 32'h0 : {24'b0, w_rx_head};
                REG_CYCLES: w_io_rdata = r_cycles;
                default:    w_io_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_q      <= 1'b0;
            r_io_rdata_q <= '0;
            r_tx_ovf     <= 1'b0;
            r_cycles     <= '0;
        end else begin
            r_sel_q      <= w_io_rd;
            r_io_rdata_q <= w_io_rdata;
            // Overflow set beats a same-cycle STATUS read clear.
            if (w_tx_ovf_evt) begin
                r_tx_ovf <= 1'b1;
            end else if (w_status_rd) begin
                r_tx_ovf <= 1'b0;
            end
            r_cycles <= w_cyc_clr ? 32'h0 : (r_cycles + 32'd1);
        end
    end

    assign ReadDataM = r_sel_q ? r_io_rdata_q : dmem_rdata;

endmodule

// File: tb/tb_mem_io_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_io_unit
//   Scoreboard bench for mem_io_unit. The driver applies directed and random
//   M-stage accesses; at every clock edge a behavioural model (queues and
//   counters) predicts load data and TX bytes and pushes them into expected
//   queues. A separate monitor compares ReadDataM, tx_data and the flow-control
//   outputs whenever the DUT presents them. A simple synchronous memory model
//   serves the dmem port.
// ---------------------------------------------------------------------------
module tb_mem_io_unit;

    localparam int D  = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   ALUOutM = '0;
    logic [31:0]   WriteDataM = '0;
    logic [3:0]    MaskM = '0;
    logic          MemReadM = 1'b0;
    logic [31:0]   ReadDataM;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_we;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;

    always #5 clk = ~clk;

    mem_io_unit #(
        .FIFO_DEPTH (D),
        .DMEM_AW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MaskM      (MaskM),
        .MemReadM   (MemReadM),
        .ReadDataM  (ReadDataM),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_unexpected(input string name);
        n_checks++;
        $display("FAIL %s: DUT presented output, expected none at %0t", name, $time);
    endtask

    function automatic logic [31:0] init_val(input int a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // ---------------- data memory environment ----------------
    logic [31:0] dmem [int];

    always @(posedge clk) begin
        logic [31:0] w;
        int          a;
        a = int'(dmem_addr);
        w = dmem.exists(a) ? dmem[a] : init_val(a);
        dmem_rdata <= w;
        for (int b = 0; b < 4; b++) if (dmem_we[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
        if (|dmem_we) dmem[a] = w;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd [$];
    logic [7:0]  exp_tx [$];
    logic [7:0]  m_rx [$];
    int          m_tx_cnt;
    bit          m_ovf;
    logic [31:0] m_cyc;

    task automatic model_clear();
        exp_rd.delete();
        exp_tx.delete();
        m_rx.delete();
        m_tx_cnt = 0;
        m_ovf    = 1'b0;
        m_cyc    = '0;
    endtask

    // Applies one clock edge worth of behaviour to the model.
    task automatic model_edge();
        bit          io, st, tx_pop, ovf_set, rx_pop, rx_push;
        logic [7:0]  off;
        int          wa;
        logic [31:0] w;
        if (reset) begin
            model_clear();
            return;
        end
        io  = ALUOutM[31];
        st  = |MaskM;
        off = {ALUOutM[7:2], 2'b00};
        wa  = int'(ALUOutM[13:2]);
        if (MemReadM) begin
            if (!io) exp_rd.push_back(ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa));
            else case (off)
                8'h00:   exp_rd.push_back({29'b0, m_ovf, (m_rx.size() > 0), (m_tx_cnt < D)});
                8'h04:   exp_rd.push_back(m_rx.size() > 0 ? {24'b0, m_rx[0]} : 32'h0);
                8'h10:   exp_rd.push_back(m_cyc);
                default: exp_rd.push_back(32'h0);
            endcase
        end
        tx_pop  = (m_tx_cnt > 0) && tx_ready;
        ovf_set = 1'b0;
        if (io && MaskM[0] && off == 8'h08) begin
            if (m_tx_cnt < D || tx_pop) begin
                exp_tx.push_back(WriteDataM[7:0]);
                m_tx_cnt++;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (tx_pop) m_tx_cnt--;
        if (ovf_set) m_ovf = 1'b1;
        else if (MemReadM && io && off == 8'h00) m_ovf = 1'b0;
        rx_push = rx_valid && (m_rx.size() < D);
        rx_pop  = MemReadM && io && off == 8'h04 && (m_rx.size() > 0);
        if (rx_pop) void'(m_rx.pop_front());
        if (rx_push) m_rx.push_back(rx_data);
        m_cyc = (io && st && off == 8'h10) ? 32'h0 : m_cyc + 32'd1;
        if (!io && st) begin
            w = ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa);
            for (int b = 0; b < 4; b++) if (MaskM[b]) w[8*b +: 8] = WriteDataM[8*b +: 8];
            ref_mem[wa] = w;
        end
    endtask

    // ---------------- monitor ----------------
    logic mon_rd;

    always @(posedge clk or posedge reset) begin
        if (reset) mon_rd <= 1'b0;
        else       mon_rd <= MemReadM;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mon_rd) begin
                if (exp_rd.size() == 0) fail_unexpected("ReadDataM");
                else check("ReadDataM", ReadDataM, exp_rd.pop_front());
            end
            check("tx_valid", {31'b0, tx_valid}, {31'b0, (m_tx_cnt > 0)});
            check("rx_ready", {31'b0, rx_ready}, {31'b0, (m_rx.size() < D)});
            check("dmem_we", {28'b0, dmem_we}, {28'b0, (ALUOutM[31] ? 4'b0000 : MaskM)});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail_unexpected("tx_data");
                else check("tx_data", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        ALUOutM = '0; WriteDataM = '0; MaskM = '0; MemReadM = 1'b0;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] m, input logic rd);
        ALUOutM = a; WriteDataM = wd; MaskM = m; MemReadM = rd;
        step();
        idle();
    endtask

    localparam logic [31:0] IO_STATUS = 32'h8000_0000;
    localparam logic [31:0] IO_RXDATA = 32'h8000_0004;
    localparam logic [31:0] IO_TXDATA = 32'h8000_0008;
    localparam logic [31:0] IO_CYCLES = 32'h8000_0010;

    initial begin
        logic [7:0] offs [7];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20};
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("reset_rdata", ReadDataM, dmem_rdata);
        reset = 1'b0;

        // Memory store/load and address steering
        ALUOutM = 32'h0000_0010; WriteDataM = 32'h1234_5678; MaskM = 4'b1111;
        #1;
        check("store_we", {28'b0, dmem_we}, 32'hF);
        check("store_addr", {20'b0, dmem_addr}, 32'h4);
        check("store_wdata", dmem_wdata, 32'h1234_5678);
        step(); idle();
        op(32'h0000_0010, '0, 4'b0000, 1'b1);
        ALUOutM = 32'h8000_0030; MaskM = 4'b1111;
        #1;
        check("io_store_we", {28'b0, dmem_we}, 32'h0);
        step(); idle();

        // TX overflow and drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) op(IO_TXDATA, 32'h41 + i, 4'b0001, 1'b0);
        op(IO_STATUS, '0, 4'b0000, 1'b1);
        op(IO_STATUS, '0, 4'b0000, 1'b1);
        tx_ready = 1'b1;
        repeat (6) step();
        tx_ready = 1'b0;

        // RX single byte
        rx_data = 8'hA5; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        op(IO_STATUS, '0, 4'b0000, 1'b1);
        op(IO_RXDATA, '0, 4'b0000, 1'b1);
        op(IO_STATUS, '0, 4'b0000, 1'b1);
        op(IO_RXDATA, '0, 4'b0000, 1'b1);

        // RX full, pop with pending byte
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'h10 + 8'(i); rx_valid = 1'b1;
            step();
        end
        rx_data = 8'h77;
        op(IO_RXDATA, '0, 4'b0000, 1'b1);
        step();
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) op(IO_RXDATA, '0, 4'b0000, 1'b1);

        // Cycle counter
        op(IO_CYCLES, '0, 4'b0000, 1'b1);
        repeat (9) step();
        op(IO_CYCLES, '0, 4'b0000, 1'b1);
        op(IO_CYCLES, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        op(IO_CYCLES, '0, 4'b0000, 1'b1);
        step();

        // Asynchronous reset during TX drain
        op(IO_TXDATA, 32'h61, 4'b0001, 1'b0);
        op(IO_TXDATA, 32'h62, 4'b0001, 1'b0);
        tx_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rx_ready", {31'b0, rx_ready}, 32'h1);
        model_clear();
        step();
        reset = 1'b0;
        op(IO_STATUS, '0, 4'b0000, 1'b1);
        op(IO_CYCLES, '0, 4'b0000, 1'b1);
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            tx_ready = 1'($urandom);
            r = $urandom_range(0, 15);
            if (r <= 2) begin
                step();
            end else if (r <= 4) begin
                op($urandom & 32'h7FF0_00FF, $urandom, 4'($urandom), 1'b0);
            end else if (r <= 6) begin
                op($urandom & 32'h7FF0_00FF, '0, 4'b0000, 1'b1);
            end else if (r <= 10) begin
                op(32'h8000_0000 | ($urandom & 32'h7FFF_FF03) | {24'b0, offs[$urandom_range(0, 6)]},
                   '0, 4'b0000, 1'b1);
            end else if (r <= 13) begin
                op(IO_TXDATA | ($urandom & 32'h7FFF_FF03), $urandom, 4'($urandom), 1'b0);
            end else if (r == 14) begin
                op(32'h8000_0000 | {24'b0, offs[$urandom_range(0, 6)]}, $urandom, 4'($urandom), 1'b0);
            end else begin
                op(IO_RXDATA, '0, 4'b0000, 1'b1);
            end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
